// File: rtl/v2c_tl_ul_master.sv
// v2c_tl_ul_master: single-outstanding TileLink-UL master for READ64_64/WRITE64_64.
// Accepts one 64-bit command, issues a Get or PutFullData on the A channel, waits
// for the matching D beat (or a timeout) and returns data/status on a response
// handshake. Non-matching D beats are drained and counted.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (write, addr, wdata)
//   rsp_valid/rsp_ready           response handshake (rdata, error, timeout)
//   a_*                           TL-UL A channel (master -> slave)
//   d_*                           TL-UL D channel (slave -> master)
//   stale_cnt                     saturating count of dropped D beats
//   busy                          transaction engine not idle
module v2c_tl_ul_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRC_W       = 4,
  parameter int unsigned SRC_ID      = 0,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [2:0]        a_size,
  output logic [SRC_W-1:0]  a_source,
  output logic [ADDR_W-1:0] a_address,
  output logic [7:0]        a_mask,
  output logic [63:0]       a_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [SRC_W-1:0]  d_source,
  input  logic              d_denied,
  input  logic              d_corrupt,
  input  logic [63:0]       d_data,
  output logic [15:0]       stale_cnt,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SRC_W-1:0] SRC      = SRC_W'(SRC_ID);
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_A_SEND, S_D_WAIT, S_RSP} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_cmd_ready, r_a_valid, r_d_ready, r_rsp_valid, r_busy;
  logic               r_write;
  logic [2:0]         r_a_opcode, r_a_size;
  logic [7:0]         r_a_mask;
  logic [SRC_W-1:0]   r_a_source;
  logic [ADDR_W-1:0]  r_a_address;
  logic [63:0]        r_a_data;
  logic [63:0]        r_rsp_rdata;
  logic               r_rsp_error, r_rsp_timeout;
  logic [CNT_W-1:0]   r_tcnt;
  logic [15:0]        r_stale;

  logic w_cmd_fire, w_a_fire, w_d_fire, w_rsp_fire;
  logic w_misaligned, w_match, w_tmo_hit, w_stale;

  // Handshake and D-beat classification
  always_comb begin
    w_cmd_fire   = cmd_valid & r_cmd_ready;
    w_a_fire     = r_a_valid & a_ready;
    w_d_fire     = d_valid & r_d_ready;
    w_rsp_fire   = r_rsp_valid & rsp_ready;
    w_misaligned = (cmd_addr[2:0] != 3'd0);
    w_match      = (r_state == S_D_WAIT) && w_d_fire && (d_source == SRC) &&
                   (d_opcode == (r_write ? OP_ACK : OP_ACK_DATA));
    // A match on the final count takes precedence over the timeout
    w_tmo_hit    = (r_state == S_D_WAIT) && (r_tcnt == TMO_LAST) && !w_match;
    w_stale      = w_d_fire && !w_match;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd_fire) w_next_state = w_misaligned ? S_RSP : S_A_SEND;
      S_A_SEND: if (w_a_fire) w_next_state = S_D_WAIT;
      S_D_WAIT: if (w_match || w_tmo_hit) w_next_state = S_RSP;
      S_RSP:    if (w_rsp_fire) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready <= 1'b0;
      r_a_valid   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_a_valid   <= (w_next_state == S_A_SEND);
      r_d_ready   <= (w_next_state != S_RSP);
      r_rsp_valid <= (w_next_state == S_RSP);
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  // Command capture, timeout counter, response capture, stale counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write       <= 1'b0;
      r_a_opcode    <= 3'd0;
      r_a_size      <= 3'd0;
      r_a_mask      <= 8'd0;
      r_a_source    <= '0;
      r_a_address   <= '0;
      r_a_data      <= 64'd0;
      r_rsp_rdata   <= 64'd0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_tcnt        <= '0;
      r_stale       <= 16'd0;
    end else begin
      if (w_cmd_fire) begin
        r_write     <= cmd_write;
        r_a_opcode  <= cmd_write ? OP_PUT_FULL : OP_GET;
        r_a_size    <= 3'd3;
        r_a_mask    <= 8'hFF;
        r_a_source  <= SRC;
        r_a_address <= cmd_addr;
        r_a_data    <= cmd_write ? cmd_wdata : 64'd0;
        if (w_misaligned) begin
          r_rsp_rdata   <= 64'd0;
          r_rsp_error   <= 1'b1;
          r_rsp_timeout <= 1'b0;
        end
      end

      if (w_a_fire)                  r_tcnt <= '0;
      else if (r_state == S_D_WAIT)  r_tcnt <= r_tcnt + CNT_W'(1);

      if (w_match) begin
        r_rsp_rdata   <= (!r_write && !(d_denied || d_corrupt)) ? d_data : 64'd0;
        r_rsp_error   <= d_denied | d_corrupt;
        r_rsp_timeout <= 1'b0;
      end else if (w_tmo_hit) begin
        r_rsp_rdata   <= 64'd0;
        r_rsp_error   <= 1'b0;
        r_rsp_timeout <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_rdata   <= 64'd0;
        r_rsp_error   <= 1'b0;
        r_rsp_timeout <= 1'b0;
      end

      if (w_stale && (r_stale != 16'hFFFF)) r_stale <= r_stale + 16'd1;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign a_valid     = r_a_valid;
  assign a_opcode    = r_a_opcode;
  assign a_param     = 3'd0;
  assign a_size      = r_a_size;
  assign a_source    = r_a_source;
  assign a_address   = r_a_address;
  assign a_mask      = r_a_mask;
  assign a_data      = r_a_data;
  assign d_ready     = r_d_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;
  assign stale_cnt   = r_stale;
  assign busy        = r_busy;

endmodule
